i2c_master_byte: RTL and testbench

- Byte-level I2C master controller that generates START, 8 data bits, ACK/NACK and STOP on open-drain SCL/SDA.
- Sits directly upstream of the I2C repeater and drives its master-side SCL/SDA bus.
- A simple valid/ready command port carries one byte operation at a time; results are returned on a single-cycle response strobe.

---
 rtl/i2c_master_byte.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START / 8 data bits / ACK / STOP on open-drain SCL/SDA, one command at a time.
// Define I2C_MASTER_STRETCH_EN to freeze the quarter counter while a slave holds a released SCL low.
module i2c_master_byte #(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = 8
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_ack,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for a command; bus lines keep their last level
    // START | four-quarter (repeated) START condition
    // BIT   | eight data bits, four quarters each, MSB first
    // ACK   | ninth clock: slave ACK on writes, master ACK/NACK on reads
    // STOP  | four-quarter STOP condition, releases the bus
    // DONE  | one-cycle response strobe
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       qtr;
    logic [2:0]       bcnt;
    logic [7:0]       shreg;
    logic             op_stop;
    logic             op_read;
    logic             op_ack;
    logic             illegal;
    logic             ack_bit;
    logic             stretch_hold;
    logic             tick;

`ifdef I2C_MASTER_STRETCH_EN
    assign stretch_hold = !scl_oe && !scl_in;
`else
    logic unused_scl;
    assign unused_scl   = scl_in;
    assign stretch_hold = 1'b0;
`endif

    assign tick = (cnt == CNT_LAST) && !stretch_hold;

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            qtr       <= 2'd0;
            bcnt      <= 3'd0;
            shreg     <= 8'h00;
            op_stop   <= 1'b0;
            op_read   <= 1'b0;
            op_ack    <= 1'b0;
            illegal   <= 1'b0;
            ack_bit   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if (state == IDLE || state == DONE)
                cnt <= '0;
            else if (tick)
                cnt <= '0;
            else if (!stretch_hold)
                cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_stop   <= cmd_stop;
                        op_read   <= cmd_read;
                        op_ack    <= cmd_ack;
                        shreg     <= cmd_wdata;
                        ack_bit   <= 1'b0;
                        qtr       <= 2'd0;
                        bcnt      <= 3'd0;
                        if (cmd_start) begin
                            // SCL is still held low from the previous byte on a repeated START
                            state  <= START;
                            scl_oe <= busy;
                            sda_oe <= 1'b0;
                            busy   <= 1'b1;
                        end else if (busy) begin
                            state  <= BIT;
                            scl_oe <= 1'b1;
                            sda_oe <= !cmd_read && !cmd_wdata[7];
                        end else begin
                            state   <= DONE;
                            illegal <= 1'b1;
                        end
                    end
                end

                START: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd0: scl_oe <= 1'b0;
                            2'd1: sda_oe <= 1'b1;
                            2'd2: scl_oe <= 1'b1;
                            default: begin
                                state  <= BIT;
                                sda_oe <= !op_read && !shreg[7];
                            end
                        endcase
                    end
                end

                BIT: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd1: scl_oe <= 1'b0;
                            2'd3: begin
                                shreg  <= {shreg[6:0], sda_in};
                                scl_oe <= 1'b1;
                                if (bcnt == 3'd7) begin
                                    state  <= ACK;
                                    sda_oe <= op_read && op_ack;
                                end else begin
                                    bcnt   <= bcnt + 3'd1;
                                    sda_oe <= !op_read && !shreg[6];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ACK: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd1: scl_oe <= 1'b0;
                            2'd3: begin
                                if (!op_read)
                                    ack_bit <= sda_in;
                                scl_oe <= 1'b1;
                                if (op_stop) begin
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state <= DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                STOP: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        case (qtr)
                            2'd0: scl_oe <= 1'b0;
                            2'd1: sda_oe <= 1'b0;
                            2'd3: begin
                                busy  <= 1'b0;
                                state <= DONE;
                            end
                            default: ;
                        endcase
                    end
                end

                DONE: begin
                    rsp_valid <= 1'b1;
                    cmd_ready <= 1'b1;
                    rsp_nack  <= illegal || (!op_read && ack_bit);
                    if (op_read && !illegal)
                        rsp_rdata <= shreg;
                    illegal   <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed plus randomized bench for i2c_master_byte with a protocol-level slave and reference model.
module tb_i2c_master_byte;

    localparam int CLK_DIV = 4;
`ifdef I2C_MASTER_STRETCH_EN
    localparam int STRETCH_DLY = 20;
`else
    localparam int STRETCH_DLY = 0;
`endif

    logic       system_clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_read;
    logic       cmd_ack;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;

    logic slave_sda = 1'b1;
    logic scl_hold  = 1'b0;

    assign scl_in = ~scl_oe & ~scl_hold;
    assign sda_in = ~sda_oe & slave_sda;

    i2c_master_byte #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
        .system_clk(system_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_ack   (cmd_ack),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .busy      (busy)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    int checks   = 0;
    int failures = 0;

    // bus observation and slave behaviour
    bit   rise_q[$];
    bit   rise_oe[$];
    bit   slave_q[$];
    int   start_cnt = 0;
    int   stop_cnt  = 0;
    bit   oe_any    = 1'b0;
    bit   stretch_arm = 1'b0;
    int   hold_cnt  = 0;
    logic prev_scl  = 1'b1;
    logic prev_sda  = 1'b1;
    logic prev_scl_oe = 1'b0;

    // reference model state
    bit         m_busy  = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    always @(negedge system_clk) begin
        if (scl_in && !prev_scl) begin
            rise_q.push_back(sda_in);
            rise_oe.push_back(sda_oe);
        end
        if (scl_in && prev_scl && prev_sda && !sda_in) start_cnt++;
        if (scl_in && prev_scl && !prev_sda && sda_in) stop_cnt++;
        if (!scl_in && prev_scl)
            slave_sda = (slave_q.size() > 0) ? slave_q.pop_front() : 1'b1;
        if (scl_oe || sda_oe) oe_any = 1'b1;
        if (stretch_arm && prev_scl_oe && !scl_oe) begin
            stretch_arm = 1'b0;
            scl_hold    = 1'b1;
            hold_cnt    = 20;
        end else if (scl_hold) begin
            hold_cnt--;
            if (hold_cnt == 0) scl_hold = 1'b0;
        end
        prev_scl_oe = scl_oe;
        prev_scl    = ~scl_oe & ~scl_hold;
        prev_sda    = ~sda_oe & slave_sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input bit st, input bit sp, input bit rd, input bit ak,
                          input logic [7:0] wd, input bit sack, input logic [7:0] sbyte,
                          input bit chain, input bit stretch, input string tag);
        bit         illegal;
        int         exp_lat;
        int         lat;
        bit         got;
        bit         exp_q[$];
        logic [7:0] bits;
        logic [15:0] exp_v;
        logic [15:0] obs_v;
        illegal = !st && !m_busy;
        exp_lat = illegal ? 2 : 2 + CLK_DIV * ((st ? 4 : 0) + 36 + (sp ? 4 : 0));
        if (stretch) exp_lat += STRETCH_DLY;
        bits = rd ? sbyte : 8'hFF;

        exp_q.delete();
        if (!illegal) begin
            if (st && m_busy) exp_q.push_back(1'b1);
            for (int i = 7; i >= 0; i--) exp_q.push_back(rd ? sbyte[i] : wd[i]);
            exp_q.push_back(rd ? !ak : !sack);
            if (sp) exp_q.push_back(1'b0);
        end

        if (!chain) @(negedge system_clk);
        rise_q.delete();
        rise_oe.delete();
        start_cnt = 0;
        stop_cnt  = 0;
        oe_any    = 1'b0;
        slave_q.delete();
        if (illegal) begin
            slave_sda = 1'b1;
        end else begin
            if (st) begin
                slave_sda = 1'b1;
                for (int i = 7; i >= 0; i--) slave_q.push_back(bits[i]);
            end else begin
                slave_sda = bits[7];
                for (int i = 6; i >= 0; i--) slave_q.push_back(bits[i]);
            end
            slave_q.push_back(rd ? 1'b1 : !sack);
            slave_q.push_back(1'b1);
        end
        if (stretch) stretch_arm = 1'b1;
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_ack   = ak;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        check({tag, "_ready"}, cmd_ready, 1'b1);
        @(posedge system_clk);
        #1 cmd_valid = 1'b0;
        check({tag, "_ready_drop"}, cmd_ready, 1'b0);

        lat = 0;
        got = 1'b0;
        while (!got && lat < 6000) begin
            @(negedge system_clk);
            lat++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end

        if (!illegal) begin
            m_busy = !sp;
            if (rd) m_rdata = sbyte;
        end

        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_nack"}, rsp_nack, illegal ? 1'b1 : (rd ? 1'b0 : !sack));
        check({tag, "_rdata"}, rsp_rdata, m_rdata);
        check({tag, "_busy"}, busy, m_busy);
        check({tag, "_ready_back"}, cmd_ready, 1'b1);
        if (illegal) begin
            check({tag, "_no_bus"}, oe_any, 1'b0);
        end else if (!stretch) begin
            exp_v = 16'h0;
            obs_v = 16'h0;
            foreach (exp_q[i]) exp_v = {exp_v[14:0], exp_q[i]};
            foreach (rise_q[i]) obs_v = {obs_v[14:0], rise_q[i]};
            check({tag, "_nbits"}, rise_q.size(), exp_q.size());
            check({tag, "_bits"}, obs_v, exp_v);
            check({tag, "_starts"}, start_cnt, st ? 1 : 0);
            check({tag, "_stops"}, stop_cnt, sp ? 1 : 0);
            if (rd && rise_oe.size() == exp_q.size())
                check({tag, "_ack_oe"}, rise_oe[exp_q.size() - (sp ? 2 : 1)], ak);
            check({tag, "_scl_oe"}, scl_oe, !sp);
            if (sp) check({tag, "_sda_oe"}, sda_oe, 1'b0);
        end
        slave_q.delete();
        slave_sda = 1'b1;
    endtask

    initial begin
        bit st, sp, rd, ak, sack;
        logic [7:0] wd, sb;
        int guard;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_read  = 1'b0;
        cmd_ack   = 1'b0;
        cmd_wdata = 8'h00;
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_nack", rsp_nack, 1'b0);
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        do_cmd(1, 1, 0, 0, 8'hA5, 1, 8'h00, 0, 0, "wr_a5");
        @(negedge system_clk);
        check("wr_a5_pulse", rsp_valid, 1'b0);

        do_cmd(1, 0, 0, 0, 8'h3C, 0, 8'h00, 0, 0, "wr_3c");
        do_cmd(0, 1, 1, 0, 8'h00, 0, 8'h5A, 1, 0, "rd_5a");

        do_cmd(0, 0, 0, 0, 8'h77, 1, 8'h00, 0, 0, "illegal");

        // reset in the middle of bit 3 of a write
        @(negedge system_clk);
        rise_q.delete();
        slave_q.delete();
        slave_sda = 1'b1;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        cmd_read  = 1'b0;
        cmd_wdata = 8'h96;
        cmd_valid = 1'b1;
        @(posedge system_clk);
        #1 cmd_valid = 1'b0;
        guard = 0;
        while (rise_q.size() < 4 && guard < 2000) begin
            @(negedge system_clk);
            guard++;
        end
        check("midrst_reach_bit3", guard < 2000, 1'b1);
        reset = 1'b1;
        @(negedge system_clk);
        check("midrst_scl_oe", scl_oe, 1'b0);
        check("midrst_sda_oe", sda_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        reset   = 1'b0;
        m_busy  = 1'b0;
        m_rdata = 8'h00;
        do_cmd(1, 1, 0, 0, 8'hC3, 1, 8'h00, 0, 0, "post_rst");

        for (int n = 0; n < 10; n++) begin
            st   = ($urandom_range(0, 3) != 0);
            sp   = $urandom_range(0, 1);
            rd   = $urandom_range(0, 1);
            ak   = $urandom_range(0, 1);
            sack = $urandom_range(0, 1);
            wd   = 8'($urandom);
            sb   = 8'($urandom);
            do_cmd(st, sp, rd, ak, wd, sack, sb, 0, 0, $sformatf("rnd%0d", n));
        end
        if (m_busy) do_cmd(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, "rnd_close");

        do_cmd(1, 1, 0, 0, 8'h5F, 0, 8'h00, 0, 1, "stretch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
